// File: rtl/conv_sched_pkg.sv
// Shared types and width helpers for the convolution loop scheduler.
// Included by every scheduler file; CONV_SCHED_PERF_CNT_EN is handled in the interface and top.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } sched_state_t;

  typedef enum logic {
    STRIDE_1 = 1'b0,
    STRIDE_2 = 1'b1
  } stride_mode_t;

  localparam int DEF_FEATURE_MAP_WIDTH  = 128;
  localparam int DEF_FEATURE_MAP_HEIGHT = 128;
  localparam int DEF_INPUT_NB_CHANNELS  = 2;
  localparam int DEF_OUTPUT_NB_CHANNELS = 16;
  localparam int DEF_KERNEL_SIZE        = 3;

  // Counter width for a loop of n iterations, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_X_W  = cnt_w(DEF_FEATURE_MAP_WIDTH);
  localparam int DEF_Y_W  = cnt_w(DEF_FEATURE_MAP_HEIGHT);
  localparam int DEF_CH_W = cnt_w(DEF_OUTPUT_NB_CHANNELS);

endpackage

// File: rtl/conv_loop_scheduler_if.sv
// Control/handshake bundle between the bench-facing source and the loop scheduler.
// CONV_SCHED_PERF_CNT_EN adds the stall_cycles/run_cycles observation signals.
interface conv_loop_scheduler_if #(
  parameter int X_W  = conv_sched_pkg::DEF_X_W,
  parameter int Y_W  = conv_sched_pkg::DEF_Y_W,
  parameter int CH_W = conv_sched_pkg::DEF_CH_W
);

  logic            start;
  logic            conv_stride_mode;
  logic            running;
  logic            a_valid;
  logic            a_ready;
  logic            mac_en;
  logic            acc_clear;
  logic            output_valid;
  logic [X_W-1:0]  output_x;
  logic [Y_W-1:0]  output_y;
  logic [CH_W-1:0] output_ch;
`ifdef CONV_SCHED_PERF_CNT_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     run_cycles;
`endif

  modport master (
    output start, conv_stride_mode, a_valid,
    input  running, a_ready, mac_en, acc_clear, output_valid,
    input  output_x, output_y, output_ch
`ifdef CONV_SCHED_PERF_CNT_EN
    , input stall_cycles, run_cycles
`endif
  );

  modport slave (
    input  start, conv_stride_mode, a_valid,
    output running, a_ready, mac_en, acc_clear, output_valid,
    output output_x, output_y, output_ch
`ifdef CONV_SCHED_PERF_CNT_EN
    , output stall_cycles, run_cycles
`endif
  );

endinterface

// File: rtl/conv_loop_scheduler_loop_counter.sv
// Wrapping loop counter: advances by step when enabled, returns to 0 once count+step passes max.
module loop_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH:0]   step,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH:0] next_sum;

  // One extra bit keeps count+step from wrapping before the compare.
  assign next_sum = {1'b0, count} + step;
  assign last     = next_sum > {1'b0, max};

  always_ff @(posedge clk) begin
    if (rst_in || clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : next_sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv_loop_scheduler.sv
// Convolution loop scheduler: walks ci->kx->ky per output and ch->x->y across outputs.
// Optional CONV_SCHED_PERF_CNT_EN adds saturating stall/run cycle counters.
module conv_loop_scheduler
  import conv_sched_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
  parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
  parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
  parameter int KERNEL_SIZE        = DEF_KERNEL_SIZE
) (
  input logic                 clk,
  input logic                 rst_in,
  conv_loop_scheduler_if.slave bus
);

  localparam int X_W  = cnt_w(FEATURE_MAP_WIDTH);
  localparam int Y_W  = cnt_w(FEATURE_MAP_HEIGHT);
  localparam int CH_W = cnt_w(OUTPUT_NB_CHANNELS);
  localparam int CI_W = cnt_w(INPUT_NB_CHANNELS);
  localparam int K_W  = cnt_w(KERNEL_SIZE);
  localparam int XS_W  = X_W + 1;
  localparam int YS_W  = Y_W + 1;
  localparam int CHS_W = CH_W + 1;
  localparam int CIS_W = CI_W + 1;
  localparam int KS_W  = K_W + 1;

  sched_state_t state, next_state;
  stride_mode_t stride_q;

  logic start_acc, running, a_ready, mac_en, acc_clear, output_valid;
  logic [CI_W-1:0] ci;
  logic [K_W-1:0]  kx, ky;
  logic [CH_W-1:0] ch;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic ci_last, kx_last, ky_last, ch_last, x_last, y_last;
  logic kx_en, ky_en, tap_done, ch_en, x_en, y_en, run_done;
  logic [XS_W-1:0] x_step;
  logic [YS_W-1:0] y_step;

  assign start_acc = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state    <= IDLE;
      stride_q <= STRIDE_1;
    end else begin
      state <= next_state;
      if (start_acc) stride_q <= stride_mode_t'(bus.conv_stride_mode);
    end
  end

  always_comb begin
    next_state   = state;
    running      = 1'b0;
    a_ready      = 1'b0;
    mac_en       = 1'b0;
    acc_clear    = 1'b0;
    output_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = FETCH;
      end
      FETCH: begin
        running   = 1'b1;
        a_ready   = 1'b1;
        mac_en    = bus.a_valid;
        acc_clear = bus.a_valid && (ci == '0) && (kx == '0) && (ky == '0);
        if (tap_done) next_state = EMIT;
      end
      EMIT: begin
        running      = 1'b1;
        output_valid = 1'b1;
        next_state   = run_done ? IDLE : FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // Inner loops step only on a handshake; outer loops step once per EMIT.
  assign kx_en    = mac_en && ci_last;
  assign ky_en    = kx_en && kx_last;
  assign tap_done = ky_en && ky_last;
  assign ch_en    = output_valid;
  assign x_en     = ch_en && ch_last;
  assign y_en     = x_en && x_last;
  assign run_done = y_en && y_last;

  assign x_step = (stride_q == STRIDE_2) ? XS_W'(2) : XS_W'(1);
  assign y_step = (stride_q == STRIDE_2) ? YS_W'(2) : YS_W'(1);

  loop_counter #(.WIDTH(CI_W)) u_ci (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(mac_en),
    .step(CIS_W'(1)), .max(CI_W'(INPUT_NB_CHANNELS - 1)), .count(ci), .last(ci_last));
  loop_counter #(.WIDTH(K_W)) u_kx (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(kx_en),
    .step(KS_W'(1)), .max(K_W'(KERNEL_SIZE - 1)), .count(kx), .last(kx_last));
  loop_counter #(.WIDTH(K_W)) u_ky (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(ky_en),
    .step(KS_W'(1)), .max(K_W'(KERNEL_SIZE - 1)), .count(ky), .last(ky_last));
  loop_counter #(.WIDTH(CH_W)) u_ch (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(ch_en),
    .step(CHS_W'(1)), .max(CH_W'(OUTPUT_NB_CHANNELS - 1)), .count(ch), .last(ch_last));
  loop_counter #(.WIDTH(X_W)) u_x (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(x_en),
    .step(x_step), .max(X_W'(FEATURE_MAP_WIDTH - 1)), .count(x), .last(x_last));
  loop_counter #(.WIDTH(Y_W)) u_y (
    .clk(clk), .rst_in(rst_in), .clear(start_acc), .en(y_en),
    .step(y_step), .max(Y_W'(FEATURE_MAP_HEIGHT - 1)), .count(y), .last(y_last));

  assign bus.running      = running;
  assign bus.a_ready      = a_ready;
  assign bus.mac_en       = mac_en;
  assign bus.acc_clear    = acc_clear;
  assign bus.output_valid = output_valid;
  assign bus.output_x     = x;
  assign bus.output_y     = y;
  assign bus.output_ch    = ch;

`ifdef CONV_SCHED_PERF_CNT_EN
  logic [31:0] stall_q, run_q;

  // Both counters restart with each accepted run and freeze while idle.
  always_ff @(posedge clk) begin
    if (rst_in || start_acc) begin
      stall_q <= '0;
      run_q   <= '0;
    end else begin
      if (a_ready && !bus.a_valid && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (running && (run_q != '1)) run_q <= run_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.run_cycles   = run_q;
`endif

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Scoreboard bench for conv_loop_scheduler on a 4x4 map, IC=2, OC=2, K=3.
// Perf-counter checks are compiled in when CONV_SCHED_PERF_CNT_EN is defined.
module tb_conv_loop_scheduler;
  import conv_sched_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int IC   = 2;
  localparam int OC   = 2;
  localparam int K    = 3;
  localparam int X_W  = cnt_w(W);
  localparam int Y_W  = cnt_w(H);
  localparam int CH_W = cnt_w(OC);
  localparam int MACS = K * K * IC;

  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [CH_W-1:0] ch;
  } coord_t;

  logic   clk = 1'b0;
  logic   rst_in = 1'b1;
  int     checks = 0;
  int     failures = 0;
  int     out_seen = 0;
  int     exp_cyc = MACS + 1;
  int     exp_run = 0;
  int     base = 0;
  bit     valid_mode = 1'b0;
  coord_t exp_q[$];

  conv_loop_scheduler_if #(.X_W(X_W), .Y_W(Y_W), .CH_W(CH_W)) bus();

  conv_loop_scheduler #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(IC),
    .OUTPUT_NB_CHANNELS(OC), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source model: a_valid always high, or alternating 0/1 starting low in every FETCH stretch.
  initial begin
    bit tog;
    tog = 1'b0;
    bus.a_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.a_ready) begin
        bus.a_valid = 1'b0;
        tog = 1'b0;
      end else if (valid_mode) begin
        bus.a_valid = tog;
        tog = ~tog;
      end else begin
        bus.a_valid = 1'b1;
      end
    end
  end

  // Monitor: per output checks coordinates, MAC count, acc_clear placement and cycle spacing.
  initial begin
    int     mac_cnt, clr_cnt, cyc_cnt;
    bit     clr_first;
    coord_t got, e;
    mac_cnt = 0; clr_cnt = 0; cyc_cnt = 0; clr_first = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_in) begin
        mac_cnt = 0; clr_cnt = 0; cyc_cnt = 0; clr_first = 1'b0;
      end else begin
        if (bus.running) cyc_cnt++;
        if (bus.mac_en) begin
          mac_cnt++;
          if (bus.acc_clear) begin
            clr_cnt++;
            if (mac_cnt == 1) clr_first = 1'b1;
          end
        end
        if (bus.output_valid) begin
          got = {bus.output_x, bus.output_y, bus.output_ch};
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", 32'(got), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("coord_xych", 32'(got), 32'(e));
          end
          checkOutput("macs_per_output", mac_cnt, MACS);
          checkOutput("acc_clear_first_only", 32'(clr_cnt) + (clr_first ? 32'd0 : 32'd100), 1);
          checkOutput("cycles_per_output", cyc_cnt, exp_cyc);
          out_seen++;
          mac_cnt = 0; clr_cnt = 0; cyc_cnt = 0; clr_first = 1'b0;
        end
      end
    end
  end

  // Queue the expected output order and pulse start.
  task automatic applyStimulus(input bit mode, input bit toggle);
    int step, n;
    coord_t c;
    step = mode ? 2 : 1;
    n = 0;
    for (int yy = 0; yy < H; yy += step)
      for (int xx = 0; xx < W; xx += step)
        for (int cc = 0; cc < OC; cc++) begin
          c.x = X_W'(xx); c.y = Y_W'(yy); c.ch = CH_W'(cc);
          exp_q.push_back(c);
          n++;
        end
    valid_mode = toggle;
    exp_cyc = toggle ? (2 * MACS + 1) : (MACS + 1);
    exp_run = n * exp_cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.conv_stride_mode = mode;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checkOutput("running_after_start", 32'(bus.running), 1);
  endtask

  task automatic wait_run_end(input bit disturb);
    int cnt;
    bit done;
    cnt = 1;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (disturb && cnt == 100) begin
        bus.start = 1'b1;
        bus.conv_stride_mode = ~bus.conv_stride_mode;
      end
      if (disturb && cnt == 101) bus.start = 1'b0;
      if (!bus.running) done = 1'b1;
      else cnt++;
    end
    checkOutput("run_ended", 32'(done), 1);
    checkOutput("run_cycles", cnt, exp_run);
    #1;
    checkOutput("outputs_pending", 32'(exp_q.size()), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.conv_stride_mode = 1'b0;
    rst_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_running", 32'(bus.running), 0);
    checkOutput("reset_a_ready", 32'(bus.a_ready), 0);
    checkOutput("reset_mac_en", 32'(bus.mac_en), 0);
    checkOutput("reset_acc_clear", 32'(bus.acc_clear), 0);
    checkOutput("reset_output_valid", 32'(bus.output_valid), 0);
    checkOutput("reset_coords", 32'({bus.output_x, bus.output_y, bus.output_ch}), 0);
    rst_in = 1'b0;

    $display("[TB] stride 1, a_valid always high");
    applyStimulus(1'b0, 1'b0);
    wait_run_end(1'b0);

    $display("[TB] stride 2");
    applyStimulus(1'b1, 1'b0);
    wait_run_end(1'b0);

    $display("[TB] a_valid alternating");
    applyStimulus(1'b0, 1'b1);
    wait_run_end(1'b0);
`ifdef CONV_SCHED_PERF_CNT_EN
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stall_cycles", bus.stall_cycles, 32 * MACS);
    checkOutput("run_cycles_cnt", bus.run_cycles, 32 * (2 * MACS + 1));
`endif

    $display("[TB] start and stride flipped mid-run");
    applyStimulus(1'b0, 1'b0);
    wait_run_end(1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("no_restart_after_ignored_start", 32'(bus.running), 0);

    $display("[TB] reset during fifth output");
    base = out_seen;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 2000 && out_seen < base + 4; i++) begin
      @(negedge clk);
      #2;
    end
    checkOutput("outputs_before_abort", 32'(out_seen - base), 4);
    repeat (5) @(negedge clk);
    #2;
    rst_in = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("abort_running", 32'(bus.running), 0);
    checkOutput("abort_a_ready", 32'(bus.a_ready), 0);
    checkOutput("abort_output_valid", 32'(bus.output_valid), 0);
    checkOutput("abort_coords", 32'({bus.output_x, bus.output_y, bus.output_ch}), 0);
    rst_in = 1'b0;
    exp_q.delete();
    applyStimulus(1'b0, 1'b0);
    wait_run_end(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
